// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Function codes, FSM state encoding and decode helpers shared
//               by the multiply/divide sequencer and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam logic [5:0] c_SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] c_SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] c_SPECIAL_DIV   = 6'h1A;
    localparam logic [5:0] c_SPECIAL_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv_func(input logic [5:0] f);
        return (f == c_SPECIAL_MULT) || (f == c_SPECIAL_MULTU) ||
               (f == c_SPECIAL_DIV)  || (f == c_SPECIAL_DIVU);
    endfunction

    function automatic logic is_mul_func(input logic [5:0] f);
        return (f == c_SPECIAL_MULT) || (f == c_SPECIAL_MULTU);
    endfunction

    function automatic logic is_div_func(input logic [5:0] f);
        return (f == c_SPECIAL_DIV) || (f == c_SPECIAL_DIVU);
    endfunction

    function automatic logic is_signed_func(input logic [5:0] f);
        return (f == c_SPECIAL_MULT) || (f == c_SPECIAL_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_datapath
// Description : Shift-add multiplier / restoring divider working on operand
//               magnitudes, with sign correction applied at the fix strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_op_mul,
    input  logic             i_signed,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic             r_mul;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_mul_top;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_neg_a = i_signed & i_a[WIDTH-1];
    assign w_neg_b = i_signed & i_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;

    // Multiply: {hi,lo} holds partial product over the not-yet-consumed multiplier bits
    assign w_sum     = {1'b0, r_hi} + {1'b0, r_opnd};
    assign w_mul_top = r_lo[0] ? w_sum : {1'b0, r_hi};

    // Divide: hi is the remainder, lo shifts dividend bits out and quotient bits in
    assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_rem = w_ge ? w_div_sub : w_rem_sh[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mul  <= 1'b0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (i_load) begin
            r_mul  <= i_op_mul;
            r_sa   <= w_neg_a;
            r_sb   <= w_neg_b;
            r_opnd <= i_op_mul ? w_mag_a : w_mag_b;
            r_hi   <= '0;
            r_lo   <= i_op_mul ? w_mag_b : w_mag_a;
        end else if (i_step) begin
            if (r_mul) begin
                r_hi <= w_mul_top[WIDTH:1];
                r_lo <= {w_mul_top[0], r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= w_div_rem;
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end
        end
    end

    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        if (r_mul) begin
            if (r_sa ^ r_sb) begin
                {w_fix_hi, w_fix_lo} = -{r_hi, r_lo};
            end
        end else begin
            if (r_sa ^ r_sb) begin
                w_fix_lo = -r_lo;
            end
            // Remainder takes the dividend's sign
            if (r_sa) begin
                w_fix_hi = -r_hi;
            end
        end
    end

    assign o_hi = i_fix ? w_fix_hi : '0;
    assign o_lo = i_fix ? w_fix_lo : '0;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO and
//               the execute-stage stall for in-flight operations.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             w_start,
    input  logic [5:0]       w_func_6,
    input  logic [WIDTH-1:0] w_rs_data_32,
    input  logic [WIDTH-1:0] w_rt_data_32,
    input  logic             w_flush,
    input  logic             w_hilo_read,
    output logic             w_busy,
    output logic             w_stall,
    output logic             w_done,
    output logic             w_div_by_zero,
    output logic [WIDTH-1:0] w_hi_32,
    output logic [WIDTH-1:0] w_lo_32
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_dbz_take;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_accept   = (r_state == IDLE) && w_start && !w_flush && is_muldiv_func(w_func_6);
    assign w_div_zero = is_div_func(w_func_6) && (w_rt_data_32 == '0);

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_fix      = 1'b0;
        w_dbz_take = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Zero divisor resolves immediately without entering CALC
                    if (w_div_zero) begin
                        w_dbz_take = 1'b1;
                    end else begin
                        w_load = 1'b1;
                        w_next = CALC;
                    end
                end
            end
            CALC: begin
                if (w_flush) begin
                    w_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_next = FIX;
                    end
                end
            end
            FIX: begin
                w_next = IDLE;
                w_fix  = !w_flush;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fix | w_dbz_take;
            r_dbz   <= w_dbz_take;
            if (w_load) begin
                r_cnt <= CNT_W'(WIDTH - 1);
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_dbz_take) begin
                r_hi <= w_rs_data_32;
                r_lo <= '1;
            end else if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_op_mul (is_mul_func(w_func_6)),
        .i_signed (is_signed_func(w_func_6)),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_a      (w_rs_data_32),
        .i_b      (w_rt_data_32),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    assign w_busy        = (r_state != IDLE);
    assign w_stall       = w_busy & (w_hilo_read | w_start);
    assign w_done        = r_done;
    assign w_div_by_zero = r_dbz;
    assign w_hi_32       = r_hi;
    assign w_lo_32       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench: directed vector table, hand sequences for
//               stall/flush/reset/back-to-back, and randomized ops vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        w_start;
    logic [5:0]  w_func_6;
    logic [31:0] w_rs_data_32;
    logic [31:0] w_rt_data_32;
    logic        w_flush;
    logic        w_hilo_read;
    logic        w_busy;
    logic        w_stall;
    logic        w_done;
    logic        w_div_by_zero;
    logic [31:0] w_hi_32;
    logic [31:0] w_lo_32;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;
    vec_t        vecs[10];

    always #5 clock = ~clock;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .w_start       (w_start),
        .w_func_6      (w_func_6),
        .w_rs_data_32  (w_rs_data_32),
        .w_rt_data_32  (w_rt_data_32),
        .w_flush       (w_flush),
        .w_hilo_read   (w_hilo_read),
        .w_busy        (w_busy),
        .w_stall       (w_stall),
        .w_done        (w_done),
        .w_div_by_zero (w_div_by_zero),
        .w_hi_32       (w_hi_32),
        .w_lo_32       (w_lo_32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results straight from integer arithmetic
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = 32'h0;
        el = 32'h0;
        if (f == F_MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            {eh, el} = p;
        end else if (f == F_MULT) begin
            p = 64'(sa * sb);
            {eh, el} = p;
        end else if (b == 32'h0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else if (f == F_DIVU) begin
            el = a / b;
            eh = a % b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            p  = 64'(q);
            el = p[31:0];
            p  = 64'(r);
            eh = p[31:0];
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        w_start      = 1'b1;
        w_func_6     = f;
        w_rs_data_32 = a;
        w_rt_data_32 = b;
        @(posedge clock);
        #1;
        w_start = 1'b0;
    endtask

    task automatic wait_check(input string name, input logic [31:0] eh, input logic [31:0] el,
                              input logic edbz);
        int          done_cyc = 0;
        int          busy_cnt = 0;
        logic [31:0] gh = 32'h0;
        logic [31:0] gl = 32'h0;
        logic        gd = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (w_busy) busy_cnt++;
            if (w_done) begin
                done_cyc = cyc;
                gh = w_hi_32;
                gl = w_lo_32;
                gd = w_div_by_zero;
                break;
            end
        end
        check({name, " done_cycle"}, 64'(done_cyc), edbz ? 64'd1 : 64'd34);
        check({name, " busy_cycles"}, 64'(busy_cnt), edbz ? 64'd0 : 64'd33);
        check({name, " hi"}, 64'(gh), 64'(eh));
        check({name, " lo"}, 64'(gl), 64'(el));
        check({name, " div_by_zero"}, 64'(gd), 64'(edbz));
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edbz);
        @(posedge clock);
        #1;
        issue(f, a, b);
        wait_check(name, eh, el, edbz);
    endtask

    task automatic watch_idle(input string name, input int ncyc);
        int done_cnt = 0;
        int busy_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            if (w_done) done_cnt++;
            if (w_busy) busy_cnt++;
        end
        check({name, " done_count"}, 64'(done_cnt), 64'd0);
        check({name, " busy_count"}, 64'(busy_cnt), 64'd0);
        check({name, " hi_kept"}, 64'(w_hi_32), 64'(last_hi));
        check({name, " lo_kept"}, 64'(w_lo_32), 64'(last_lo));
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        logic [5:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        int          stall_cnt;
        int          done_cyc;
        logic        stall_done;
        logic [31:0] gh;
        logic [31:0] gl;

        vecs[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{F_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4] = '{F_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[9] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

        reset_n      = 1'b0;
        w_start      = 1'b0;
        w_func_6     = 6'h0;
        w_rs_data_32 = 32'h0;
        w_rt_data_32 = 32'h0;
        w_flush      = 1'b0;
        w_hilo_read  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", 64'(w_busy), 64'd0);
        check("reset stall", 64'(w_stall), 64'd0);
        check("reset done", 64'(w_done), 64'd0);
        check("reset dbz", 64'(w_div_by_zero), 64'd0);
        check("reset hi", 64'(w_hi_32), 64'd0);
        check("reset lo", 64'(w_lo_32), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        // Stall with HI/LO read held from t2 and an ignored second start at t5
        @(posedge clock);
        #1;
        issue(F_MULT, 32'h0000_0007, 32'hFFFF_FFFA);
        stall_cnt  = 0;
        done_cyc   = 0;
        stall_done = 1'b1;
        gh         = 32'h0;
        gl         = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            w_hilo_read = (k >= 2);
            w_start     = (k == 5);
            if (k == 5) begin
                w_func_6     = F_MULTU;
                w_rs_data_32 = 32'h0000_0003;
                w_rt_data_32 = 32'h0000_0003;
            end
            @(negedge clock);
            if (w_stall) stall_cnt++;
            if (w_done) begin
                done_cyc   = k;
                stall_done = w_stall;
                gh         = w_hi_32;
                gl         = w_lo_32;
                break;
            end
            @(posedge clock);
            #1;
        end
        w_hilo_read = 1'b0;
        w_start     = 1'b0;
        check("stall cycles", 64'(stall_cnt), 64'd32);
        check("stall at done", 64'(stall_done), 64'd0);
        check("stall done_cycle", 64'(done_cyc), 64'd34);
        check("stall hi", 64'(gh), 64'hFFFF_FFFF);
        check("stall lo", 64'(gl), 64'hFFFF_FFD6);
        last_hi = 32'hFFFF_FFFF;
        last_lo = 32'hFFFF_FFD6;
        watch_idle("after_stall", 3);

        // Back-to-back: new start during the done cycle of the previous op
        run_op("b2b_first", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        #1;
        issue(F_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_check("b2b_second", 32'h0000_0001, 32'h0000_0000, 1'b0);

        // Flush during CALC at t10
        @(posedge clock);
        #1;
        issue(F_MULT, 32'h1234_5678, 32'h0000_0009);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        w_flush = 1'b1;
        @(negedge clock);
        check("flush busy_t10", 64'(w_busy), 64'd1);
        @(posedge clock);
        #1;
        w_flush = 1'b0;
        @(negedge clock);
        check("flush busy_t11", 64'(w_busy), 64'd0);
        watch_idle("flush", 40);

        // Flush in IDLE wins over a simultaneous start
        @(posedge clock);
        #1;
        w_flush = 1'b1;
        issue(F_MULTU, 32'd5, 32'd5);
        w_flush = 1'b0;
        watch_idle("flush_start", 40);

        // Invalid function code is ignored
        @(posedge clock);
        #1;
        issue(6'h20, 32'd5, 32'd5);
        watch_idle("bad_func", 40);

        // Asynchronous reset mid-operation
        @(posedge clock);
        #1;
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        w_hilo_read = 1'b1;
        reset_n     = 1'b0;
        #1;
        check("async_rst busy", 64'(w_busy), 64'd0);
        check("async_rst stall", 64'(w_stall), 64'd0);
        check("async_rst done", 64'(w_done), 64'd0);
        check("async_rst hi", 64'(w_hi_32), 64'd0);
        check("async_rst lo", 64'(w_lo_32), 64'd0);
        @(posedge clock);
        #1;
        reset_n     = 1'b1;
        w_hilo_read = 1'b0;
        run_op("post_rst", F_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            int sel;
            rf  = 6'(F_MULT + 6'($urandom_range(0, 3)));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'h0;
            else if (sel == 1) rb = 32'($urandom_range(1, 15));
            else if (sel == 2) rb = 32'hFFFF_FFFF;
            else               rb = $urandom;
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            model(rf, ra, rb, eh, el, ed);
            run_op($sformatf("rand%0d", n), rf, ra, rb, eh, el, ed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the MULT/MULTU/DIV/DIVU class emitted by the decoder (SPECIAL, w_alu_op=1).
- Sequences a 1-bit-per-cycle shift-add multiplier and restoring divider, owns the HI/LO registers, and asserts a pipeline stall while a result or the unit is unavailable.
- Sits beside the ALU in the execute stage; MFHI/MFLO consumers read w_hi_32/w_lo_32.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- w_start  in  1  issue request, valid for one cycle with operands
- w_func_6  in  6  function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- w_rs_data_32  in  WIDTH  operand A (multiplicand / dividend)
- w_rt_data_32  in  WIDTH  operand B (multiplier / divisor)
- w_flush  in  1  cancel the in-flight operation
- w_hilo_read  in  1  the current instruction reads HI or LO
- w_busy  out  1  operation in progress
- w_stall  out  1  issue stage must hold
- w_done  out  1  one-cycle pulse; HI/LO updated
- w_div_by_zero  out  1  one-cycle pulse with w_done for a zero-divisor divide
- w_hi_32  out  WIDTH  HI register
- w_lo_32  out  WIDTH  LO register

Behaviour:
- Reset: all outputs 0, HI/LO = 0, state IDLE, counter 0. Reset takes effect immediately, including mid-operation; partial results are discarded.
- States:
  - IDLE: accept work.
  - CALC: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- Accept: w_start=1 in IDLE with a valid w_func_6 captures operands on the edge (t0). For signed ops, operands are captured as magnitudes, plus sign flags sA and sB. The counter loads WIDTH-1 and the state goes to CALC.
- Invalid w_func_6 with w_start: ignored, no state change.
- CALC, one iteration per cycle at t1..t32:
  - MUL: 2*WIDTH accumulator; add A<<i when B bit i is set.
  - DIV: restoring; shift the remainder left, trial-subtract B using a WIDTH+1-bit compare, set the quotient bit.
  - Counter decrements; at 0, the state goes to FIX.
- FIX (t33), then HI/LO written on its closing edge:
  - MUL: {HI,LO} = product, negated (2*WIDTH) when sA^sB.
  - DIV: LO = quotient, negated if sA^sB; HI = remainder, negated if sA.
- Latency: results and w_done=1 in cycle t34 (state IDLE). w_busy=1 for t1..t33.
- DIV 0x80000000 / 0xFFFFFFFF (signed overflow): LO=0x80000000, HI=0. This falls out of the magnitude algorithm; no special case.
- Divide by zero: on accept, CALC is skipped. HI=rs, LO=all-ones, w_done=1 and w_div_by_zero=1 in t1; w_busy never asserts.
- w_stall = w_busy & (w_hilo_read | w_start) (combinational).
- w_start while busy: ignored. The issuer must hold it, which w_stall enforces.
- w_flush: in CALC or FIX, the state goes to IDLE on the next edge. HI/LO keep their prior values and no w_done is produced. In IDLE, flush has priority over a simultaneous w_start, so the start is dropped.
- w_start and w_done in the same cycle (back-to-back): the new operation is accepted normally, and HI/LO remain at the new results until the next FIX.

Decomposition:
- Shared package/include (alongside the ISA code defines): SPECIAL_MULT/MULTU/DIV/DIVU func codes and state encodings IDLE=2'd0, CALC=2'd1, FIX=2'd2.
- One natural sub-module, muldiv_datapath:
  - holds the accumulator/remainder shift registers and the adder/subtractor;
  - is controlled by the FSM through op_mul, load, step and fix strobes.
- The FSM, counter and HI/LO stay in muldiv_sequencer.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> w_done at t34; HI=0xFFFFFFFE, LO=0x00000001; w_busy high exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1.
- DIVU rs=0x1234, rt=0 -> at t1: w_done=1, w_div_by_zero=1, HI=0x1234, LO=0xFFFFFFFF; w_busy stays 0.
- MULT issued, w_hilo_read=1 held from t2 -> w_stall=1 through t33, 0 at t34. A second w_start at t5 is ignored, and the results match the first op.
- Flush at t10 -> IDLE at t11, HI/LO unchanged, no w_done. Repeat with reset_n low at t10 -> outputs 0 asynchronously; normal operation after release.
